// File: rtl/sw_fifo_reader.sv
// Consumer side of a shared-memory FIFO: polls the producer line, fetches buffer lines
// out of order through an 8-slot reorder buffer and writes consumption progress back.
module sw_fifo_reader #(
   parameter int POLL_CYCLES          = 32,
   parameter int TAG_W                = 9,
   parameter int PRODUCER_LINE_OFFSET = 1,
   parameter int CONSUMER_LINE_OFFSET = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [57:0]      fifo_base_addr,
   input  logic             setup_fifo,
   output logic             fifo_done,
   output logic [57:0]      fifo_tx_rd_addr,
   output logic [TAG_W-1:0] fifo_tx_rd_tag,
   output logic             fifo_tx_rd_valid,
   input  logic             fifo_tx_rd_ready,
   input  logic [TAG_W-1:0] fifo_rx_rd_tag,
   input  logic [511:0]     fifo_rx_data,
   input  logic             fifo_rx_rd_valid,
   output logic [57:0]      fifo_tx_wr_addr,
   output logic [511:0]     fifo_tx_wr_data,
   output logic             fifo_tx_wr_valid,
   input  logic             fifo_tx_wr_ready,
   input  logic             fifo_rx_wr_valid,
   output logic [511:0]     usr_rx_data,
   output logic             usr_rx_valid,
   input  logic             usr_rx_ready
);

   typedef enum logic [2:0] {IDLE, REQ_CONFIG, READ_CONFIG, RUN, FINAL_UPDATE, DONE} state_t;

   state_t             state_q, state_d;
   logic [57:0]        base_q, base_d, buff_q, buff_d;
   logic [31:0]        size_cl_q, size_cl_d, thr_q, thr_d;
   logic [31:0]        produced_q, produced_d, requested_q, requested_d;
   logic [31:0]        consumed_q, consumed_d, last_upd_q, last_upd_d;
   logic [31:0]        rd_idx_q, rd_idx_d, poll_cnt_q, poll_cnt_d;
   logic               pdone_q, pdone_d, ctl_pend_q, ctl_pend_d;
   logic               wr_pend_q, wr_pend_d, final_sent_q, final_sent_d;
   logic               rd_valid_q, rd_valid_d;
   logic [57:0]        rd_addr_q, rd_addr_d;
   logic [TAG_W-1:0]   rd_tag_q, rd_tag_d;
   logic               wr_valid_q, wr_valid_d;
   logic [57:0]        wr_addr_q, wr_addr_d;
   logic [511:0]       wr_data_q, wr_data_d;
   logic [2:0]         head_q, head_d, tail_q, tail_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [7:0]         filled_q, filled_d;
   logic [511:0]       rob_q [8];

   logic               rd_acc, wr_acc, rsp_ctl, rsp_dat, drain, alloc;
   logic [31:0]        avail, cons_diff;

   assign fifo_tx_rd_valid = rd_valid_q;
   assign fifo_tx_rd_addr  = rd_addr_q;
   assign fifo_tx_rd_tag   = rd_tag_q;
   assign fifo_tx_wr_valid = wr_valid_q;
   assign fifo_tx_wr_addr  = wr_addr_q;
   assign fifo_tx_wr_data  = wr_data_q;
   assign usr_rx_valid     = filled_q[head_q];
   assign usr_rx_data      = rob_q[head_q];
   assign fifo_done        = (state_q == DONE);

   assign rd_acc    = rd_valid_q & fifo_tx_rd_ready;
   assign wr_acc    = wr_valid_q & fifo_tx_wr_ready;
   assign rsp_ctl   = fifo_rx_rd_valid & ~fifo_rx_rd_tag[TAG_W-1] & (state_q != IDLE);
   assign rsp_dat   = fifo_rx_rd_valid &  fifo_rx_rd_tag[TAG_W-1] & (state_q != IDLE);
   assign drain     = usr_rx_valid & usr_rx_ready;
   assign avail     = produced_q - requested_q;
   assign cons_diff = consumed_q - last_upd_q;

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      buff_d       = buff_q;
      size_cl_d    = size_cl_q;
      thr_d        = thr_q;
      produced_d   = produced_q;
      requested_d  = requested_q;
      consumed_d   = consumed_q;
      last_upd_d   = last_upd_q;
      rd_idx_d     = rd_idx_q;
      poll_cnt_d   = poll_cnt_q;
      pdone_d      = pdone_q;
      ctl_pend_d   = ctl_pend_q;
      wr_pend_d    = wr_pend_q;
      final_sent_d = final_sent_q;
      rd_valid_d   = rd_valid_q;
      rd_addr_d    = rd_addr_q;
      rd_tag_d     = rd_tag_q;
      wr_valid_d   = wr_valid_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      head_d       = head_q;
      tail_d       = tail_q;
      filled_d     = filled_q;
      alloc        = 1'b0;

      if (rd_acc) begin
         rd_valid_d = 1'b0;
         if (rd_tag_q[TAG_W-1]) requested_d = requested_q + 32'd64;
      end
      if (wr_acc) wr_valid_d = 1'b0;
      if (fifo_rx_wr_valid) wr_pend_d = 1'b0;
      if (rsp_ctl) ctl_pend_d = 1'b0;
      // Fill and drain always hit different slots, so both updates apply in one cycle.
      if (rsp_dat) filled_d[fifo_rx_rd_tag[2:0]] = 1'b1;
      if (drain) begin
         filled_d[head_q] = 1'b0;
         head_d           = head_q + 3'd1;
         consumed_d       = consumed_q + 32'd64;
      end

      case (state_q)
         IDLE: begin
            if (setup_fifo) begin
               base_d  = fifo_base_addr;
               state_d = REQ_CONFIG;
            end
         end
         REQ_CONFIG: begin
            if (!rd_valid_q) begin
               rd_valid_d = 1'b1;
               rd_addr_d  = base_q;
               rd_tag_d   = '0;
               ctl_pend_d = 1'b1;
               state_d    = READ_CONFIG;
            end
         end
         READ_CONFIG: begin
            if (rsp_ctl && fifo_rx_rd_tag == '0) begin
               buff_d    = fifo_rx_data[63:6];
               size_cl_d = {6'd0, fifo_rx_data[127:102]};
               thr_d     = fifo_rx_data[159:128];
               state_d   = RUN;
            end
         end
         RUN: begin
            if (rsp_ctl && ctl_pend_q) begin
               produced_d = fifo_rx_data[63:32];
               pdone_d    = fifo_rx_data[96];
            end
            if (!rd_valid_q) begin
               if (avail != 32'd0 && !avail[31] && !cnt_q[3]) begin
                  rd_valid_d             = 1'b1;
                  rd_addr_d              = buff_q + 58'(rd_idx_q);
                  rd_tag_d               = '0;
                  rd_tag_d[TAG_W-1]      = 1'b1;
                  rd_tag_d[2:0]          = tail_q;
                  tail_d                 = tail_q + 3'd1;
                  alloc                  = 1'b1;
                  rd_idx_d               = (rd_idx_q == size_cl_q - 32'd1) ? 32'd0 : rd_idx_q + 32'd1;
                  poll_cnt_d             = '0;
               end else if (avail == 32'd0 && !pdone_q && !ctl_pend_q) begin
                  if (poll_cnt_q == 32'(POLL_CYCLES)) begin
                     rd_valid_d = 1'b1;
                     rd_addr_d  = base_q + 58'(PRODUCER_LINE_OFFSET);
                     rd_tag_d   = TAG_W'(1);
                     ctl_pend_d = 1'b1;
                     poll_cnt_d = '0;
                  end else begin
                     poll_cnt_d = poll_cnt_q + 32'd1;
                  end
               end else begin
                  poll_cnt_d = '0;
               end
            end
            if (!wr_pend_q && cons_diff >= thr_q) begin
               wr_valid_d        = 1'b1;
               wr_pend_d         = 1'b1;
               wr_addr_d         = base_q + 58'(CONSUMER_LINE_OFFSET);
               wr_data_d         = '0;
               wr_data_d[63:32]  = consumed_q;
               last_upd_d        = consumed_q;
            end
            if (pdone_q && consumed_q == produced_q && cnt_q == 4'd0 && !rd_valid_q)
               state_d = FINAL_UPDATE;
         end
         FINAL_UPDATE: begin
            if (!final_sent_q && !wr_pend_q) begin
               wr_valid_d       = 1'b1;
               wr_pend_d        = 1'b1;
               final_sent_d     = 1'b1;
               wr_addr_d        = base_q + 58'(CONSUMER_LINE_OFFSET);
               wr_data_d        = '0;
               wr_data_d[63:32] = consumed_q;
               wr_data_d[96]    = 1'b1;
            end else if (final_sent_q && fifo_rx_wr_valid) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d      = IDLE;
            produced_d   = '0;
            requested_d  = '0;
            consumed_d   = '0;
            last_upd_d   = '0;
            rd_idx_d     = '0;
            poll_cnt_d   = '0;
            pdone_d      = 1'b0;
            final_sent_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      cnt_d = cnt_q + {3'd0, alloc} - {3'd0, drain};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         base_q       <= '0;
         buff_q       <= '0;
         size_cl_q    <= '0;
         thr_q        <= '0;
         produced_q   <= '0;
         requested_q  <= '0;
         consumed_q   <= '0;
         last_upd_q   <= '0;
         rd_idx_q     <= '0;
         poll_cnt_q   <= '0;
         pdone_q      <= 1'b0;
         ctl_pend_q   <= 1'b0;
         wr_pend_q    <= 1'b0;
         final_sent_q <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_addr_q    <= '0;
         rd_tag_q     <= '0;
         wr_valid_q   <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         cnt_q        <= '0;
         filled_q     <= '0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         buff_q       <= buff_d;
         size_cl_q    <= size_cl_d;
         thr_q        <= thr_d;
         produced_q   <= produced_d;
         requested_q  <= requested_d;
         consumed_q   <= consumed_d;
         last_upd_q   <= last_upd_d;
         rd_idx_q     <= rd_idx_d;
         poll_cnt_q   <= poll_cnt_d;
         pdone_q      <= pdone_d;
         ctl_pend_q   <= ctl_pend_d;
         wr_pend_q    <= wr_pend_d;
         final_sent_q <= final_sent_d;
         rd_valid_q   <= rd_valid_d;
         rd_addr_q    <= rd_addr_d;
         rd_tag_q     <= rd_tag_d;
         wr_valid_q   <= wr_valid_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         cnt_q        <= cnt_d;
         filled_q     <= filled_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) rob_q[i] <= '0;
      end else if (rsp_dat) begin
         rob_q[fifo_rx_rd_tag[2:0]] <= fifo_rx_data;
      end
   end

endmodule

// File: tb/tb_sw_fifo_reader.sv
// Randomized bench: a shared-memory model answers reads out of order with random delays and
// a queue-based scoreboard predicts every address, user beat and consumer-line write.
module tb_sw_fifo_reader;
   localparam int TAG_W = 9;
   localparam int POLL  = 8;

   logic             clk, rst;
   logic [57:0]      fifo_base_addr;
   logic             setup_fifo, fifo_done;
   logic [57:0]      fifo_tx_rd_addr;
   logic [TAG_W-1:0] fifo_tx_rd_tag;
   logic             fifo_tx_rd_valid, fifo_tx_rd_ready;
   logic [TAG_W-1:0] fifo_rx_rd_tag;
   logic [511:0]     fifo_rx_data;
   logic             fifo_rx_rd_valid;
   logic [57:0]      fifo_tx_wr_addr;
   logic [511:0]     fifo_tx_wr_data;
   logic             fifo_tx_wr_valid, fifo_tx_wr_ready, fifo_rx_wr_valid;
   logic [511:0]     usr_rx_data;
   logic             usr_rx_valid, usr_rx_ready;

   sw_fifo_reader #(.POLL_CYCLES(POLL), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .fifo_base_addr(fifo_base_addr), .setup_fifo(setup_fifo),
      .fifo_done(fifo_done), .fifo_tx_rd_addr(fifo_tx_rd_addr), .fifo_tx_rd_tag(fifo_tx_rd_tag),
      .fifo_tx_rd_valid(fifo_tx_rd_valid), .fifo_tx_rd_ready(fifo_tx_rd_ready),
      .fifo_rx_rd_tag(fifo_rx_rd_tag), .fifo_rx_data(fifo_rx_data), .fifo_rx_rd_valid(fifo_rx_rd_valid),
      .fifo_tx_wr_addr(fifo_tx_wr_addr), .fifo_tx_wr_data(fifo_tx_wr_data),
      .fifo_tx_wr_valid(fifo_tx_wr_valid), .fifo_tx_wr_ready(fifo_tx_wr_ready),
      .fifo_rx_wr_valid(fifo_rx_wr_valid), .usr_rx_data(usr_rx_data), .usr_rx_valid(usr_rx_valid),
      .usr_rx_ready(usr_rx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [57:0]      addr;
   } rdreq_t;

   rdreq_t      pend[$];
   logic [31:0] wr_log[$];
   logic [57:0] m_base, m_buff;
   int          m_size;
   logic [31:0] m_thr, m_total, prod_tb, m_cons, last_wr, salt;
   bit          pdone_tb, usr_hold, hold_data, fast_wr, final_seen;
   int          n_data_rd, n_cfg_rd, wr_ack_dly, done_pulses;
   int          n_chk, n_pass;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [511:0] mkdata(input logic [57:0] a);
      logic [511:0] d;
      for (int i = 0; i < 8; i++) d[i*64 +: 64] = {6'(i), a} ^ {salt, ~salt};
      return d;
   endfunction

   task automatic mdl_init(input logic [57:0] base, buff, input int size,
                           input logic [31:0] thr, total, input bit full);
      m_base = base; m_buff = buff; m_size = size; m_thr = thr; m_total = total;
      prod_tb = full ? total : 32'd0;
      pdone_tb = 1'b0; m_cons = '0; last_wr = '0; final_seen = 1'b0;
      n_data_rd = 0; n_cfg_rd = 0; wr_ack_dly = -1; done_pulses = 0;
      pend.delete(); wr_log.delete();
      salt = $urandom;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rd"}, {fifo_tx_rd_valid, fifo_tx_rd_addr, fifo_tx_rd_tag}, '0);
      chk({tag, "_wr"}, {fifo_tx_wr_valid, fifo_tx_wr_addr}, '0);
      chk({tag, "_wrd"}, fifo_tx_wr_data, '0);
      chk({tag, "_usr"}, {usr_rx_valid, fifo_done}, '0);
      chk({tag, "_usrd"}, usr_rx_data, '0);
   endtask

   // One clock of environment: memory responses, acks, producer progress and scoreboard.
   task automatic tick();
      int           k;
      rdreq_t       r;
      logic [511:0] d, rest;
      logic [31:0]  v;
      fifo_tx_rd_ready = ($urandom_range(0, 3) != 0);
      fifo_tx_wr_ready = fast_wr ? 1'b1 : ($urandom_range(0, 2) != 0);
      usr_rx_ready     = usr_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      fifo_rx_rd_valid = 1'b0; fifo_rx_rd_tag = '0; fifo_rx_data = '0; fifo_rx_wr_valid = 1'b0;
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
         k = $urandom_range(0, pend.size() - 1);
         r = pend[k];
         if (!(hold_data && r.tag[TAG_W-1])) begin
            if (r.tag[TAG_W-1]) d = mkdata(r.addr);
            else if (r.tag == '0) begin
               d = '0; d[95:64] = $urandom; d[511:480] = $urandom;
               d[63:6] = m_buff; d[127:96] = 32'(m_size * 64); d[159:128] = m_thr;
            end else begin
               d = '0; d[31:0] = $urandom; d[63:32] = prod_tb; d[96] = pdone_tb;
               if (prod_tb == m_total) pdone_tb = 1'b1;
            end
            fifo_rx_rd_valid = 1'b1; fifo_rx_rd_tag = r.tag; fifo_rx_data = d;
            pend.delete(k);
         end
      end
      if (wr_ack_dly == 0) begin fifo_rx_wr_valid = 1'b1; wr_ack_dly = -1; end
      else if (wr_ack_dly > 0) wr_ack_dly--;
      if (prod_tb < m_total && $urandom_range(0, 7) == 0) begin
         prod_tb = prod_tb + 32'(64 * $urandom_range(1, 4));
         if (prod_tb > m_total) prod_tb = m_total;
      end

      if (fifo_tx_rd_valid && fifo_tx_rd_ready) begin
         r.tag = fifo_tx_rd_tag; r.addr = fifo_tx_rd_addr;
         if (!fifo_tx_rd_tag[TAG_W-1]) begin
            if (fifo_tx_rd_addr == m_base) begin n_cfg_rd++; chk("cfg_tag", fifo_tx_rd_tag, '0); end
            else chk("poll_addr", fifo_tx_rd_addr, m_base + 58'd1);
         end else begin
            chk("rd_addr", fifo_tx_rd_addr, m_buff + 58'(n_data_rd % m_size));
            n_data_rd++;
            chk("rob_cap", (n_data_rd - int'(m_cons / 64)) <= 8, 1);
         end
         pend.push_back(r);
      end
      if (usr_rx_valid && usr_rx_ready) begin
         chk("beat", usr_rx_data, mkdata(m_buff + 58'((m_cons / 64) % 32'(m_size))));
         m_cons = m_cons + 32'd64;
      end
      if (fifo_tx_wr_valid && fifo_tx_wr_ready) begin
         chk("wr_addr", fifo_tx_wr_addr, m_base + 58'd2);
         v = fifo_tx_wr_data[63:32];
         rest = fifo_tx_wr_data; rest[63:32] = '0; rest[96] = 1'b0;
         chk("wr_zero", rest, '0);
         if (fifo_tx_wr_data[96]) begin
            chk("fin_val", v, m_total);
            chk("fin_cons", m_cons, m_total);
            final_seen = 1'b1;
         end else begin
            chk("wr_thr", (v - last_wr) >= m_thr, 1);
            chk("wr_cons", v <= m_cons, 1);
            wr_log.push_back(v);
            last_wr = v;
         end
         wr_ack_dly = fast_wr ? 0 : $urandom_range(0, 2);
      end
      if (fifo_done === 1'b1) done_pulses++;
      @(posedge clk); #1;
   endtask

   task automatic run_stream(input logic [57:0] base, buff, input int size, input logic [31:0] thr,
                             total, input bit full, fw, input int hold_cycles);
      int cyc;
      mdl_init(base, buff, size, thr, total, full);
      fast_wr = fw; hold_data = 1'b0; usr_hold = (hold_cycles > 0);
      fifo_base_addr = base; setup_fifo = 1'b1;
      tick();
      setup_fifo = 1'b0;
      cyc = 0;
      while (done_pulses == 0 && cyc < 8000) begin
         if (cyc == 12) begin setup_fifo = 1'b1; fifo_base_addr = ~base; end
         if (hold_cycles > 0 && cyc == hold_cycles) begin
            chk("bp_reads", n_data_rd, 8);
            usr_hold = 1'b0;
         end
         tick();
         setup_fifo = 1'b0;
         cyc++;
      end
      chk("timeout", done_pulses > 0, 1);
      repeat (4) tick();
      chk("done_pulse", done_pulses, 1);
      chk("final_wr", final_seen, 1);
      chk("beats", m_cons, total);
      chk("n_rd", 32'(n_data_rd * 64), total);
      chk("cfg_reads", n_cfg_rd, 1);
      chk("idle", {fifo_tx_rd_valid, fifo_tx_wr_valid, usr_rx_valid, fifo_done}, '0);
   endtask

   task automatic reset_case();
      mdl_init(58'h4000, 58'h200, 8, 32'd256, 32'd640, 1'b1);
      fast_wr = 1'b0; hold_data = 1'b1; usr_hold = 1'b0;
      fifo_base_addr = m_base; setup_fifo = 1'b1;
      tick();
      setup_fifo = 1'b0;
      repeat (80) tick();
      chk("rst_pend", n_data_rd > 0, 1);
      rst = 1'b1;
      tick();
      chk_idle("rst_mid");
      rst = 1'b0;
      fifo_rx_rd_valid = 1'b1;
      fifo_rx_rd_tag   = TAG_W'(9'h100);
      fifo_rx_data     = mkdata(m_buff);
      fifo_rx_wr_valid = 1'b1;
      usr_rx_ready     = 1'b1;
      @(posedge clk); #1;
      chk_idle("late_rsp");
      fifo_rx_rd_valid = 1'b0; fifo_rx_wr_valid = 1'b0;
      hold_data = 1'b0;
      pend.delete();
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      rst = 1'b1; setup_fifo = 1'b0; fifo_base_addr = '0;
      fifo_tx_rd_ready = 1'b0; fifo_tx_wr_ready = 1'b0; usr_rx_ready = 1'b0;
      fifo_rx_rd_valid = 1'b0; fifo_rx_rd_tag = '0; fifo_rx_data = '0; fifo_rx_wr_valid = 1'b0;
      usr_hold = 1'b0; hold_data = 1'b0; fast_wr = 1'b0;
      mdl_init('0, '0, 1, '0, '0, 1'b1);
      repeat (2) tick();
      chk_idle("reset");
      rst = 1'b0;

      // Full 640 bytes visible at first poll, 8-line ring, consumer stalled at start.
      run_stream(58'h1000, 58'h100, 8, 32'd256, 32'd640, 1'b1, 1'b1, 200);
      chk("wr_count", wr_log.size(), 2);
      if (wr_log.size() >= 2) begin
         chk("wr_256", wr_log[0], 32'd256);
         chk("wr_512", wr_log[1], 32'd512);
      end

      // Short stream finishing below threshold: only the final write appears.
      run_stream(58'h2000, 58'h3F0, 4, 32'd1024, 32'd128, 1'b1, 1'b0, 0);
      chk("end_nowr", wr_log.size(), 0);

      reset_case();

      for (int s = 0; s < 4; s++) begin
         run_stream({$urandom, $urandom} & 58'h3FF_FFFF_FFFF_0000, {$urandom, $urandom},
                    4 << $urandom_range(0, 2), 32'(64 * $urandom_range(1, 6)),
                    32'(64 * $urandom_range(1, 30)), 1'b0, 1'b0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sw_fifo_reader.md
SW_FIFO_READER -- requirements
Module: sw_fifo_reader

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter POLL_CYCLES, default 32, idle cycles between producer-line polls.
REQ-003 Parameter TAG_W, default 9, read-tag width.
REQ-004 Parameter PRODUCER_LINE_OFFSET, default 1, CL offset of producer line from struct base.
REQ-005 Parameter CONSUMER_LINE_OFFSET, default 2, CL offset of consumer line from struct base.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 fifo_base_addr  in  58  CL address of the FIFO struct (config line at offset 0).
REQ-009 setup_fifo  in  1  start pulse, sampled in IDLE.
REQ-010 fifo_done  out  1  one-cycle pulse at end of stream.
REQ-011 fifo_tx_rd_addr/_tag/_valid  out  58/TAG_W/1  read request; fifo_tx_rd_ready  in  1.
REQ-012 fifo_rx_rd_tag  in  TAG_W, fifo_rx_data  in  512, fifo_rx_rd_valid  in  1  read responses, any order.
REQ-013 fifo_tx_wr_addr/_data/_valid  out  58/512/1  write request; fifo_tx_wr_ready  in  1; fifo_rx_wr_valid  in  1  write ack.
REQ-014 usr_rx_data  out  512, usr_rx_valid  out  1, usr_rx_ready  in  1  in-order data stream to user.

Function
REQ-015 FSM states SHALL be IDLE, REQ_CONFIG, READ_CONFIG, RUN, FINAL_UPDATE, DONE; setup_fifo in IDLE latches fifo_base_addr and enters REQ_CONFIG.
REQ-016 REQ_CONFIG SHALL issue a read of base with tag 0, then enter READ_CONFIG; on tag-0 response latch buff_addr=data[63:6], sizeBytes=data[127:96], threshold=data[159:128], sizeCL=sizeBytes>>6, enter RUN.
REQ-017 Every tx valid SHALL be registered and held with addr/tag/data stable until accepted (valid & ready).
REQ-018 Control reads use tag MSB=0; data reads use tag MSB=1 with tag[2:0]=reorder-buffer slot; at most one control read outstanding.
REQ-019 Poll: when requestedBytes==producedBytes and producer_done=0, wait POLL_CYCLES cycles then read base+PRODUCER_LINE_OFFSET; response latches producedBytes=data[63:32], producer_done=data[96].
REQ-020 Data read SHALL issue when requestedBytes<producedBytes and a reorder slot is free, at buff_addr+rd_idx; rd_idx wraps from sizeCL-1 to 0; requestedBytes+=64 on acceptance; data reads take priority over polls.
REQ-021 Reorder buffer: 8 slots allocated in order, filled by tag, drained in allocation order to usr_rx_*; usr_rx_valid only when head slot is filled; response and drain of same slot-free cycle SHALL both take effect.
REQ-022 consumedBytes+=64 on each usr_rx_valid & usr_rx_ready; all byte counters 32-bit, compared by modular difference.
REQ-023 When consumedBytes-lastUpdated>=threshold and no write outstanding, write base+CONSUMER_LINE_OFFSET with data[63:32]=consumedBytes, all other bits 0; lastUpdated=consumedBytes; one write outstanding, cleared by fifo_rx_wr_valid.
REQ-024 When producer_done=1, consumedBytes==producedBytes and buffer empty, enter FINAL_UPDATE: after any outstanding write acks, write consumer line with [63:32]=consumedBytes and bit 96=1.
REQ-025 On ack of final write enter DONE, pulse fifo_done for one cycle, return to IDLE, clear all counters.
REQ-026 setup_fifo outside IDLE SHALL be ignored.

Reset
REQ-027 rst SHALL clear FSM to IDLE, all valids, fifo_done, counters, producer_done, reorder buffer and address/tag/data outputs to 0, including mid-transfer.

Verification
REQ-028 Config: config data size=1024, threshold=256, buff_addr=0x100 -> next rd_addr=base+1 with tag MSB 0.
REQ-029 Stream: producedBytes=640, size 512 -> 10 data reads at 0x100..0x107, then 0x100,0x101 (wrap); 10 user beats in order.
REQ-030 Reorder: return tags of slots 3,1,0,2 -> user receives slot order 0,1,2,3 data unchanged.
REQ-031 Backpressure: usr_rx_ready=0 -> at most 8 data reads outstanding, no 9th issued; consumer writes at consumed 256,512.
REQ-032 End: producer_done=1, producedBytes=128, consumed 128 -> final write bit96=1,[63:32]=128; ack -> fifo_done single pulse, IDLE.
REQ-033 Reset mid-RUN with outstanding reads -> all outputs 0 next cycle; late responses ignored in IDLE.
